nonrestoring_div: RTL

- Sequential unsigned N-bit divider using the non-restoring algorithm.
- Each iteration is a single add-or-subtract of the divisor into an (N+1)-bit signed partial remainder, chosen by the sign of the previous result.
- Natural companion to the combinational adder/subtracter in the arithmetic library: the adder/subtracter is the datapath primitive, this block sequences it.
- Start/busy/done handshake for use by a control FSM or testbench.

---
 rtl/nonrestoring_div_pkg.sv | 19 +
 rtl/nonrestoring_div_addsub_n.sv | 19 +
 rtl/nonrestoring_div.sv | 133 +++++++++++++
 3 files changed

// File: rtl/nonrestoring_div_pkg.sv
// Shared definitions for the non-restoring divider: state encoding and
// the quotient pattern reported on divide-by-zero.
package nonrestoring_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DBZ_Q_BIT = 1'b1;

  function automatic logic is_ready(input state_t st);
    return (st == IDLE) || (st == DONE);
  endfunction

endpackage

// File: rtl/nonrestoring_div_addsub_n.sv
// N-bit two's-complement adder/subtracter. Subtraction is formed as
// a + ~b + 1, and the carry-out is discarded.
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s
);

  logic [N-1:0] b_x_s;
  logic [N-1:0] cin_s;

  assign b_x_s = b ^ {N{sub}};
  assign cin_s = {{(N-1){1'b0}}, sub};
  assign s     = a + b_x_s + cin_s;

endmodule

// File: rtl/nonrestoring_div.sv
// Sequential unsigned divider using the non-restoring algorithm: one
// shared add/sub per iteration, a final sign fix-up, start/busy/done handshake.
module nonrestoring_div #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  import nonrestoring_div_pkg::*;

  state_t           state_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   d_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic [WIDTH:0]   as_a_s;
  logic [WIDTH:0]   as_s_s;
  logic             as_sub_s;

  // Operand select for the shared adder: shifted remainder in ITER, raw remainder in FIX.
  always_comb begin
    as_a_s   = r_r;
    as_sub_s = 1'b0;
    if (state_r == ITER) begin
      as_a_s   = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
      as_sub_s = ~r_r[WIDTH];
    end else begin
      as_a_s   = r_r;
      as_sub_s = 1'b0;
    end
  end

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .a   (as_a_s),
    .b   (d_r),
    .sub (as_sub_s),
    .s   (as_s_s)
  );

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= {(WIDTH + 1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {(WIDTH + 1){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start && is_ready(state_r)) begin
            if (divisor != {WIDTH{1'b0}}) begin
              r_r     <= {(WIDTH + 1){1'b0}};
              q_r     <= dividend;
              d_r     <= {1'b0, divisor};
              cnt_r   <= {CNT_W{1'b0}};
              dbz_r   <= 1'b0;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              state_r <= ITER;
            end else begin
              quotient_r  <= {WIDTH{DBZ_Q_BIT}};
              remainder_r <= dividend;
              dbz_r       <= 1'b1;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ITER: begin
          r_r   <= as_s_s;
          q_r   <= {q_r[WIDTH-2:0], ~as_s_s[WIDTH]};
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= ITER;
          end
        end
        FIX: begin
          // A negative final remainder gets one corrective add of the divisor.
          if (r_r[WIDTH]) begin
            r_r         <= as_s_s;
            remainder_r <= as_s_s[WIDTH-1:0];
          end else begin
            remainder_r <= r_r[WIDTH-1:0];
          end
          quotient_r <= q_r;
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          state_r    <= DONE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule
